// File: rtl/keynsham_wrbuf_pkg.sv
// Shared types for the keynsham posted write buffer: queue entry, CPU request,
// drain FSM encoding and the SDRAM window decode.
package keynsham_wrbuf_pkg;

  localparam int unsigned addr_w        = 30;
  localparam int unsigned data_w        = 32;
  localparam int unsigned sel_w         = 4;
  localparam int unsigned wrbuf_entry_w = addr_w + data_w + sel_w;

  typedef struct packed {
    logic [addr_w-1:0] addr;
    logic [data_w-1:0] data;
    logic [sel_w-1:0]  bytesel;
  } wrbuf_entry_t;

  typedef struct packed {
    wrbuf_entry_t entry;
    logic         wr_en;
  } cpu_req_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PASS  = 3'd3,
    ST_PWAIT = 3'd4
  } wrbuf_state_e;

  // Byte-address window hit, same base/size encoding as cs_gen.
  function automatic logic in_window(input logic [addr_w-1:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] byte_addr;
    logic [32:0] limit;
    byte_addr = {1'b0, addr, 2'b00};
    limit     = 33'(base) + 33'(size);
    return (byte_addr >= 33'(base)) && (byte_addr < limit);
  endfunction

endpackage

// File: rtl/keynsham_wrbuf_fifo.sv
// Synchronous FIFO of posted writes; exposes the head and the entry behind it
// so the drain FSM can issue back-to-back without a bubble.
module keynsham_wrbuf_fifo
  import keynsham_wrbuf_pkg::*;
#(
  parameter int unsigned depth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  wrbuf_entry_t           wdata,
  output wrbuf_entry_t           head,
  output wrbuf_entry_t           head_next,
  output logic [$clog2(depth):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned ptr_w = $clog2(depth);
  localparam int unsigned cnt_w = ptr_w + 1;

  wrbuf_entry_t     mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [ptr_w-1:0] rd_ptr_inc;
  logic [cnt_w-1:0] count_d;

  assign rd_ptr_inc = rd_ptr + ptr_w'(1);
  assign count_d    = count + cnt_w'(push) - cnt_w'(pop);
  assign head       = mem[rd_ptr];
  assign head_next  = mem[rd_ptr_inc];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      count <= count_d;
      full  <= (count_d == cnt_w'(depth));
      empty <= (count_d == '0);
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/keynsham_wrbuf.sv
// Posted write buffer between the CPU data bus and the keynsham SDRAM port:
// window writes are acked at once and drained in order; everything else waits.
module keynsham_wrbuf
  import keynsham_wrbuf_pkg::*;
#(
  parameter int unsigned depth       = 4,
  parameter logic [31:0] bus_address = 32'h0,
  parameter logic [31:0] bus_size    = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_access,
  input  logic [addr_w-1:0] c_addr,
  input  logic [data_w-1:0] c_wr_val,
  input  logic              c_wr_en,
  input  logic [sel_w-1:0]  c_bytesel,
  output logic              c_ack,
  output logic [data_w-1:0] c_data,
  output logic              c_error,
  output logic              m_access,
  output logic [addr_w-1:0] m_addr,
  output logic [data_w-1:0] m_wr_val,
  output logic              m_wr_en,
  output logic [sel_w-1:0]  m_bytesel,
  input  logic              m_ack,
  input  logic [data_w-1:0] m_data,
  input  logic              m_error,
  output logic              empty,
  output logic              wr_err
);

  localparam int unsigned cnt_w = $clog2(depth) + 1;

  wrbuf_state_e     state_q, state_d;
  cpu_req_t         c_in, req_q, cur_req;
  logic             req_pend_q, pending, post, push, pop, pass_ack, done;
  wrbuf_entry_t     head, head_next, m_src;
  logic [cnt_w-1:0] count;
  logic             full, fifo_empty, fifo_empty_d;

  assign c_in     = {c_addr, c_wr_val, c_bytesel, c_wr_en};
  assign cur_req  = c_access ? c_in : req_q;
  assign pending  = c_access | req_pend_q;
  assign post     = pending & cur_req.wr_en &
                    in_window(cur_req.entry.addr, bus_address, bus_size);
  assign push     = post & ~full;
  assign pop      = (state_q == ST_WAIT) & m_ack;
  assign pass_ack = (state_q == ST_PWAIT) & m_ack;
  assign done     = push | pass_ack;
  assign fifo_empty_d = ((count == '0) && !push) ||
                        ((count == cnt_w'(1)) && pop && !push);

  keynsham_wrbuf_fifo #(.depth(depth)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .wdata     (cur_req.entry),
    .head      (head),
    .head_next (head_next),
    .count     (count),
    .full      (full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Drain has priority; pass-through only starts once the queue is empty.
  always_comb begin
    state_d = state_q;
    m_src   = head;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty)           state_d = ST_ISSUE;
        else if (pending && !post) state_d = ST_PASS;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (m_ack) begin
          // head is popped this edge, so the next issue takes the entry behind it
          if (count > cnt_w'(1)) begin
            state_d = ST_ISSUE;
            m_src   = head_next;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_PASS:  state_d = ST_PWAIT;
      ST_PWAIT: if (m_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pend_q <= 1'b0;
      req_q      <= '0;
    end else begin
      req_pend_q <= pending & ~done;
      if (c_access) req_q <= c_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_access  <= 1'b0;
      m_addr    <= '0;
      m_wr_val  <= '0;
      m_wr_en   <= 1'b0;
      m_bytesel <= '0;
      c_ack     <= 1'b0;
      c_data    <= '0;
      c_error   <= 1'b0;
      empty     <= 1'b1;
      wr_err    <= 1'b0;
    end else begin
      m_access <= (state_d == ST_ISSUE) || (state_d == ST_PASS);
      if (state_d == ST_ISSUE) begin
        m_addr    <= m_src.addr;
        m_wr_val  <= m_src.data;
        m_bytesel <= m_src.bytesel;
        m_wr_en   <= 1'b1;
      end else if (state_d == ST_PASS) begin
        m_addr    <= cur_req.entry.addr;
        m_wr_val  <= cur_req.entry.data;
        m_bytesel <= cur_req.entry.bytesel;
        m_wr_en   <= cur_req.wr_en;
      end
      c_ack   <= done;
      c_data  <= (pass_ack && !req_q.wr_en) ? m_data : '0;
      c_error <= pass_ack & m_error;
      empty   <= fifo_empty_d && (state_d == ST_IDLE);
      wr_err  <= wr_err | (pop & m_error);
    end
  end

endmodule

// File: tb/tb_keynsham_wrbuf.sv
// Directed plus randomized bench for keynsham_wrbuf against a memory responder
// and an in-order reference memory.
module tb_keynsham_wrbuf;

  localparam int unsigned DEPTH     = 4;
  localparam logic [31:0] WIN_BASE  = 32'h0000_0000;
  localparam logic [31:0] WIN_SIZE  = 32'h0100_0000;
  localparam logic [29:0] CTRL_ADDR = 30'h0800_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_access = 1'b0;
  logic [29:0] c_addr = '0;
  logic [31:0] c_wr_val = '0;
  logic        c_wr_en = 1'b0;
  logic [3:0]  c_bytesel = '0;
  logic        c_ack, c_error, m_access, m_wr_en, empty, wr_err;
  logic [31:0] c_data, m_wr_val;
  logic [29:0] m_addr;
  logic [3:0]  m_bytesel;
  logic        m_ack, m_error;
  logic [31:0] m_data;

  keynsham_wrbuf #(.depth(DEPTH), .bus_address(WIN_BASE), .bus_size(WIN_SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_access(c_access), .c_addr(c_addr), .c_wr_val(c_wr_val), .c_wr_en(c_wr_en),
    .c_bytesel(c_bytesel), .c_ack(c_ack), .c_data(c_data), .c_error(c_error),
    .m_access(m_access), .m_addr(m_addr), .m_wr_val(m_wr_val), .m_wr_en(m_wr_en),
    .m_bytesel(m_bytesel), .m_ack(m_ack), .m_data(m_data), .m_error(m_error),
    .empty(empty), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        wr;
    int          iss;
    int          ack;
  } txn_t;

  txn_t        mlog[$];
  txn_t        exp_q[$];
  logic [31:0] sdram [logic [29:0]];
  logic [31:0] refm  [logic [29:0]];
  int          mem_lat = 1;
  logic        err_en = 1'b0;
  logic [29:0] err_addr = '0;
  int          checks = 0;
  int          passes = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] val,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = val[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    return sdram.exists(a) ? sdram[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    return refm.exists(a) ? refm[a] : 32'h0;
  endfunction

  function automatic logic is_post(input logic [29:0] a, input logic wr);
    logic [32:0] b;
    b = 33'({a, 2'b00});
    return wr && (b >= 33'(WIN_BASE)) && (b < 33'(WIN_BASE) + 33'(WIN_SIZE));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // SDRAM responder: acks each access mem_lat cycles later (0 = random 1..4).
  initial begin : mem_model
    txn_t t;
    int   lat;
    m_ack = 1'b0; m_data = '0; m_error = 1'b0;
    forever begin
      @(negedge clk);
      while (m_access) begin
        t.addr = m_addr; t.data = m_wr_val; t.sel = m_bytesel; t.wr = m_wr_en;
        t.iss = cyc; t.ack = 0;
        lat = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
        repeat (lat) @(negedge clk);
        m_error = err_en && (t.addr == err_addr);
        m_data  = t.wr ? 32'h0 : mem_rd(t.addr);
        if (t.wr && !m_error) sdram[t.addr] = merge(mem_rd(t.addr), t.data, t.sel);
        m_ack = 1'b1;
        t.ack = cyc;
        mlog.push_back(t);
        @(negedge clk);
        m_ack = 1'b0; m_error = 1'b0; m_data = '0;
      end
    end
  end

  task automatic cpu_req(input logic [29:0] a, input logic [31:0] d, input logic wr,
                         input logic [3:0] sel, output int lat, output logic [31:0] rd,
                         output logic er, output int acyc);
    int n;
    c_addr = a; c_wr_val = d; c_wr_en = wr; c_bytesel = sel; c_access = 1'b1;
    @(negedge clk);
    c_access = 1'b0;
    n = 1;
    while (!c_ack && n < 300) begin @(negedge clk); n++; end
    chk("cpu_ack_arrived", 64'(c_ack), 64'd1);
    lat = n; rd = c_data; er = c_error; acyc = cyc;
  endtask

  // One CPU access checked against the reference memory and error rule.
  task automatic do_op(input logic [29:0] a, input logic [31:0] d, input logic wr,
                       input logic [3:0] sel, input string tag,
                       output int lat, output int acyc, output logic [31:0] rd);
    logic er, post, hit_err;
    txn_t t;
    post    = is_post(a, wr);
    hit_err = err_en && (a == err_addr);
    cpu_req(a, d, wr, sel, lat, rd, er, acyc);
    chk({tag, "_c_error"}, 64'(er), 64'(!post && hit_err));
    chk({tag, "_c_data"}, 64'(rd), 64'(wr ? 32'h0 : ref_rd(a)));
    if (wr && !hit_err) refm[a] = merge(ref_rd(a), d, sel);
    t.addr = a; t.data = d; t.sel = sel; t.wr = wr; t.iss = 0; t.ack = 0;
    exp_q.push_back(t);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (!empty && n < 500) begin @(negedge clk); n++; end
    chk("drain_done", 64'(empty), 64'd1);
  endtask

  initial begin
    int          lat, acyc, n, base, late_acks, late_access;
    logic [31:0] rd;
    logic        er;
    int          lats[5];
    int          acycs[5];
    logic [29:0] a;
    int          r;

    repeat (2) @(negedge clk);
    chk("rst_c_ack", 64'(c_ack), 64'd0);
    chk("rst_m_access", 64'(m_access), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_wr_err", 64'(wr_err), 64'd0);
    chk("rst_c_data", 64'(c_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a drain discards the queue and ignores the late ack.
    mem_lat = 6;
    for (int i = 0; i < 3; i++) begin
      cpu_req(30'h300 + 30'(i), 32'ha000_0000 + 32'(i), 1'b1, 4'hf, lat, rd, er, acyc);
      chk($sformatf("rst_pre_lat%0d", i), 64'(lat), 64'd1);
    end
    n = 0;
    while (!m_access && n < 100) begin @(negedge clk); n++; end
    chk("rst_mid_drain_access", 64'(m_access), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_m_access", 64'(m_access), 64'd0);
    chk("rst_mid_empty", 64'(empty), 64'd1);
    chk("rst_mid_c_ack", 64'(c_ack), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    late_acks = 0; late_access = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      late_acks   += int'(c_ack);
      late_access += int'(m_access);
    end
    chk("rst_late_ack_no_c_ack", 64'(late_acks), 64'd0);
    chk("rst_queue_discarded", 64'(late_access), 64'd0);
    chk("rst_after_empty", 64'(empty), 64'd1);
    mlog.delete();

    // Single posted write.
    mem_lat = 2;
    base = mlog.size();
    do_op(30'h100, 32'hdeadbeef, 1'b1, 4'b1111, "single", lat, acyc, rd);
    chk("single_lat", 64'(lat), 64'd1);
    chk("single_busy", 64'(empty), 64'd0);
    n = 0;
    while (n < 100) begin
      @(negedge clk); #1;
      if (m_ack) break;
      n++;
    end
    chk("single_m_ack_seen", 64'(m_ack), 64'd1);
    @(negedge clk);
    chk("single_empty_after_ack", 64'(empty), 64'd1);
    chk("single_log_len", 64'(mlog.size()), 64'(base + 1));
    if (mlog.size() > base) begin
      chk("single_m_addr", 64'(mlog[base].addr), 64'h100);
      chk("single_m_data", 64'(mlog[base].data), 64'hdeadbeef);
      chk("single_m_sel", 64'(mlog[base].sel), 64'hf);
      chk("single_m_wr", 64'(mlog[base].wr), 64'd1);
    end

    // depth+1 writes against a slow memory: the last one waits for a pop.
    mem_lat = 5;
    base = mlog.size();
    for (int i = 0; i < 5; i++) begin
      do_op(30'h180 + 30'(i), $urandom, 1'b1, 4'hf, "burst", lat, acyc, rd);
      lats[i] = lat; acycs[i] = acyc;
    end
    wait_empty();
    for (int i = 0; i < 4; i++) chk($sformatf("burst_lat%0d", i), 64'(lats[i]), 64'd1);
    chk("burst_5th_held", 64'(lats[4] > 1), 64'd1);
    chk("burst_5th_after_pop",
        64'((mlog.size() > base) && (acycs[4] > mlog[base].ack)), 64'd1);

    // Read-after-write stays ordered behind the posted write.
    mem_lat = 3;
    base = mlog.size();
    do_op(30'h200, 32'h11223344, 1'b1, 4'hf, "raw_wr", lat, acyc, rd);
    do_op(30'h200, 32'h0, 1'b0, 4'hf, "raw_rd", lat, acyc, rd);
    chk("raw_rd_value", 64'(rd), 64'h11223344);
    chk("raw_rd_after_wr_ack",
        64'((mlog.size() > base + 1) && !mlog[base + 1].wr &&
            (mlog[base + 1].iss > mlog[base].ack)), 64'd1);

    // Writes outside the window pass through with the memory error.
    wait_empty();
    err_en = 1'b1; err_addr = CTRL_ADDR; mem_lat = 2;
    do_op(CTRL_ADDR, 32'h5a5a_a5a5, 1'b1, 4'hf, "ctrl_wr", lat, acyc, rd);
    chk("ctrl_wr_lat", 64'(lat), 64'(mem_lat + 2));
    chk("ctrl_wr_no_wr_err", 64'(wr_err), 64'd0);
    do_op(CTRL_ADDR + 30'd1, 32'h0, 1'b0, 4'hf, "ctrl_rd", lat, acyc, rd);
    chk("ctrl_rd_lat", 64'(lat), 64'(mem_lat + 2));

    // Posted write that errors only sets the sticky flag.
    err_addr = 30'h50;
    do_op(30'h50, 32'hcafe_f00d, 1'b1, 4'hf, "perr", lat, acyc, rd);
    chk("perr_lat", 64'(lat), 64'd1);
    chk("perr_wr_err_before_drain", 64'(wr_err), 64'd0);
    wait_empty();
    chk("perr_wr_err_set", 64'(wr_err), 64'd1);
    err_en = 1'b0;

    // Random mix of posted writes, reads and pass-through accesses.
    mem_lat = 0;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r = int'($urandom_range(0, 9));
      a = (r < 8) ? 30'h40 + 30'(r) : CTRL_ADDR + 30'(r - 8);
      do_op(a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
            "rand", lat, acyc, rd);
    end
    wait_empty();

    chk("log_len", 64'(mlog.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mlog.size(); i++) begin
      chk($sformatf("log%0d_addr", i), 64'(mlog[i].addr), 64'(exp_q[i].addr));
      chk($sformatf("log%0d_wr", i), 64'(mlog[i].wr), 64'(exp_q[i].wr));
      if (exp_q[i].wr) begin
        chk($sformatf("log%0d_data", i), 64'(mlog[i].data), 64'(exp_q[i].data));
        chk($sformatf("log%0d_sel", i), 64'(mlog[i].sel), 64'(exp_q[i].sel));
      end
    end

    chk("wr_err_sticky", 64'(wr_err), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("wr_err_reset", 64'(wr_err), 64'd0);
    chk("final_rst_empty", 64'(empty), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
